// File: rtl/processor_debugger_hex_tx_formatter_pkg.sv
// Shared constants and types for the debugger hex transmit path.
// The ASCII frame characters are also used by the RX command parser.
package processor_debugger_hex_tx_formatter_pkg;

    localparam logic [7:0] LP_CHAR_START = 8'h23;
    localparam logic [7:0] LP_CHAR_SPLIT = 8'h2C;
    localparam logic [7:0] LP_CHAR_CR    = 8'h0D;
    localparam logic [7:0] LP_CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DIGIT = 3'd2,
        ST_SPLIT = 3'd3,
        ST_STOP  = 3'd4,
        ST_EOL   = 3'd5
    } tx_state_t;

    typedef struct packed {
        logic start_en;
        logic split_en;
        logic stop_en;
    } tx_flags_t;

endpackage

// File: rtl/processor_debugger_hex_tx_formatter_if.sv
// Word-request side (debugger FSM) and byte side (UART) of the hex formatter.
// master = surrounding logic driving requests; slave = the formatter itself.
interface processor_debugger_hex_tx_formatter_if #(
    parameter int P_DATA_W = 32
);
    logic                iTXD_REQ;
    logic                oTXD_BUSY;
    logic                iTXD_START_EN;
    logic                iTXD_SPLIT_EN;
    logic                iTXD_STOP_EN;
    logic [P_DATA_W-1:0] iTXD_DATA;
    logic                oUART_REQ;
    logic                iUART_BUSY;
    logic [7:0]          oUART_DATA;

    modport master (
        output iTXD_REQ, iTXD_START_EN, iTXD_SPLIT_EN, iTXD_STOP_EN, iTXD_DATA, iUART_BUSY,
        input  oTXD_BUSY, oUART_REQ, oUART_DATA
    );

    modport slave (
        input  iTXD_REQ, iTXD_START_EN, iTXD_SPLIT_EN, iTXD_STOP_EN, iTXD_DATA, iUART_BUSY,
        output oTXD_BUSY, oUART_REQ, oUART_DATA
    );

endinterface

// File: rtl/processor_debugger_hex_tx_formatter_nibble2ascii.sv
// 4-bit value to uppercase ASCII hex digit; purely combinational.
module processor_debugger_hex_tx_formatter_nibble2ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            // 'A' - 10 = 8'h37
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/processor_debugger_hex_tx_formatter.sv
// Turns one debugger word per request into an ASCII-hex frame fragment:
// optional '#', the digits MS nibble first, then ',' or CR LF or nothing.
module processor_debugger_hex_tx_formatter
    import processor_debugger_hex_tx_formatter_pkg::*;
#(
    parameter int         P_DATA_W     = 32,
    parameter logic [7:0] P_START_CHAR = LP_CHAR_START,
    parameter logic [7:0] P_SPLIT_CHAR = LP_CHAR_SPLIT,
    parameter logic [7:0] P_STOP_CHAR  = LP_CHAR_CR
) (
    input logic iCLOCK,
    input logic iRESET_SYNC,
    processor_debugger_hex_tx_formatter_if.slave bus
);

    localparam int LP_DIGITS = P_DATA_W / 4;
    localparam int LP_CNT_W  = (LP_DIGITS > 1) ? $clog2(LP_DIGITS) : 1;
    localparam logic [LP_CNT_W-1:0] LP_CNT_TOP = LP_CNT_W'(LP_DIGITS - 1);

    tx_state_t           state_reg, state_next;
    logic                guard_reg, guard_next;
    logic [LP_CNT_W-1:0] cnt_reg,   cnt_next;
    logic [P_DATA_W-1:0] data_reg,  data_next;
    tx_flags_t           flags_reg, flags_next;
    logic [7:0]          byte_reg,  byte_next;

    logic [3:0] nibble_arr [LP_DIGITS];
    logic [3:0] enc_nibble;
    logic [7:0] enc_ascii;
    logic       uart_req;

    for (genvar gi = 0; gi < LP_DIGITS; gi++) begin : g_nibble
        assign nibble_arr[gi] = data_reg[gi*4 +: 4];
    end

    // The encoder always looks at the digit that will be shown next, so the
    // byte register can be loaded on the same edge the state advances.
    always_comb begin
        case (state_reg)
            ST_IDLE:  enc_nibble = bus.iTXD_DATA[P_DATA_W-1 -: 4];
            ST_START: enc_nibble = nibble_arr[LP_DIGITS-1];
            default:  enc_nibble = nibble_arr[cnt_reg - LP_CNT_W'(1)];
        endcase
    end

    processor_debugger_hex_tx_formatter_nibble2ascii u_enc (
        .nibble (enc_nibble),
        .ascii  (enc_ascii)
    );

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_reg <= ST_IDLE;
            guard_reg <= 1'b0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            flags_reg <= '0;
            byte_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            guard_reg <= guard_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            flags_reg <= flags_next;
            byte_reg  <= byte_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        guard_next = guard_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        flags_next = flags_reg;
        byte_next  = byte_reg;
        uart_req   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.iTXD_REQ) begin
                    data_next  = bus.iTXD_DATA;
                    flags_next = '{start_en: bus.iTXD_START_EN,
                                   split_en: bus.iTXD_SPLIT_EN,
                                   stop_en:  bus.iTXD_STOP_EN};
                    cnt_next   = LP_CNT_TOP;
                    guard_next = 1'b0;
                    if (bus.iTXD_START_EN) begin
                        state_next = ST_START;
                        byte_next  = P_START_CHAR;
                    end else begin
                        state_next = ST_DIGIT;
                        byte_next  = enc_ascii;
                    end
                end
            end

            default: begin
                if (!guard_reg) begin
                    // Strobe once, then a quiet cycle so the UART can raise busy.
                    if (!bus.iUART_BUSY) begin
                        uart_req   = 1'b1;
                        guard_next = 1'b1;
                    end
                end else begin
                    guard_next = 1'b0;
                    case (state_reg)
                        ST_START: begin
                            state_next = ST_DIGIT;
                            byte_next  = enc_ascii;
                        end
                        ST_DIGIT: begin
                            if (cnt_reg != '0) begin
                                cnt_next  = cnt_reg - LP_CNT_W'(1);
                                byte_next = enc_ascii;
                            end else if (flags_reg.stop_en) begin
                                state_next = ST_STOP;
                                byte_next  = P_STOP_CHAR;
                            end else if (flags_reg.split_en) begin
                                state_next = ST_SPLIT;
                                byte_next  = P_SPLIT_CHAR;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end
                        ST_STOP: begin
                            state_next = ST_EOL;
                            byte_next  = LP_CHAR_LF;
                        end
                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign bus.oTXD_BUSY  = (state_reg != ST_IDLE);
    assign bus.oUART_REQ  = uart_req;
    assign bus.oUART_DATA = byte_reg;

endmodule

// File: tb/tb_processor_debugger_hex_tx_formatter.sv
// Directed bench for the hex TX formatter: reset, framing, chained words,
// UART backpressure, flag priority and mid-frame reset.
module tb_processor_debugger_hex_tx_formatter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] got_q [$];
    int         stb_q [$];
    logic       bp_mode = 1'b0;
    int         bp_cnt = 0;

    processor_debugger_hex_tx_formatter_if #(.P_DATA_W(32)) tx_if ();

    processor_debugger_hex_tx_formatter #(.P_DATA_W(32)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (tx_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string s;
        s = "0123456789ABCDEF";
        return s[int'(n)];
    endfunction

    // Byte monitor and UART model; in backpressure mode the UART stays busy
    // for a random 0-20 cycles after every strobe.
    initial begin
        tx_if.iUART_BUSY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_if.oUART_REQ === 1'b1) begin
                check_eq("strobe_while_uart_busy", {31'd0, tx_if.iUART_BUSY}, 32'd0);
                got_q.push_back(tx_if.oUART_DATA);
                stb_q.push_back(cyc);
                if (bp_mode) bp_cnt = $urandom_range(0, 20);
            end else if (bp_cnt > 0) begin
                bp_cnt--;
            end
            tx_if.iUART_BUSY = bp_mode && (bp_cnt != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic s, input logic sp,
                             input logic st, output int acc_cyc);
        int t;
        t = 0;
        while (tx_if.oTXD_BUSY !== 1'b0 && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) check_eq("send_wait_timeout", t, 0);
        tx_if.iTXD_DATA     = d;
        tx_if.iTXD_START_EN = s;
        tx_if.iTXD_SPLIT_EN = sp;
        tx_if.iTXD_STOP_EN  = st;
        tx_if.iTXD_REQ      = 1'b1;
        tick();
        acc_cyc        = cyc;
        tx_if.iTXD_REQ = 1'b0;
    endtask

    task automatic wait_idle(output int fall_cyc);
        int t;
        t = 0;
        while (tx_if.oTXD_BUSY !== 1'b0 && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) check_eq("idle_wait_timeout", t, 0);
        fall_cyc = cyc;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp[$]);
        check_eq({tag, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got_q.size())
                check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp[i]});
        end
        $display("frame %s: %0d bytes received, %0d expected", tag, got_q.size(), exp.size());
        got_q.delete();
        stb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q [$];
        logic [31:0] wv;
        int acc;
        int fall;

        tx_if.iTXD_REQ      = 1'b0;
        tx_if.iTXD_START_EN = 1'b0;
        tx_if.iTXD_SPLIT_EN = 1'b0;
        tx_if.iTXD_STOP_EN  = 1'b0;
        tx_if.iTXD_DATA     = 32'h0;

        // T1: reset with a request held high
        rst = 1'b1;
        tx_if.iTXD_REQ  = 1'b1;
        tx_if.iTXD_DATA = 32'h55AA55AA;
        tick();
        tick();
        check_eq("rst_busy",     {31'd0, tx_if.oTXD_BUSY}, 32'd0);
        check_eq("rst_uart_req", {31'd0, tx_if.oUART_REQ}, 32'd0);
        check_eq("rst_uart_data", {24'd0, tx_if.oUART_DATA}, 32'd0);
        tx_if.iTXD_REQ = 1'b0;
        rst = 1'b0;
        repeat (6) tick();
        check_eq("post_rst_busy", {31'd0, tx_if.oTXD_BUSY}, 32'd0);
        check_eq("post_rst_bytes", got_q.size(), 0);
        $display("frame T1_reset: %0d bytes after reset", got_q.size());

        // T2: one framed word, UART always idle
        send_word(32'h1234ABCD, 1'b1, 1'b0, 1'b1, acc);
        wait_idle(fall);
        check_eq("t2_busy_fall", fall - acc, 22);
        if (stb_q.size() > 0) check_eq("t2_first_strobe", stb_q[0] - acc, 0);
        for (int i = 1; i < stb_q.size(); i++)
            check_eq($sformatf("t2_gap%0d", i), stb_q[i] - stb_q[i-1], 2);
        exp_q = '{8'h23, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        expect_frame("T2_single", exp_q);

        // T3: 37-word split chain, 335 bytes total
        exp_q.delete();
        for (int w = 0; w < 37; w++) begin
            wv = 32'(w);
            if (w == 0) exp_q.push_back(8'h23);
            for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(wv[k*4 +: 4]));
            if (w < 36) exp_q.push_back(8'h2C);
            else begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
        for (int w = 0; w < 37; w++) begin
            send_word(32'(w), (w == 0), (w < 36), (w == 36), acc);
        end
        wait_idle(fall);
        expect_frame("T3_chain", exp_q);

        // T4: random UART backpressure
        bp_mode = 1'b1;
        send_word(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(fall);
        bp_mode = 1'b0;
        repeat (3) tick();
        exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        expect_frame("T4_backpressure", exp_q);

        // T5: SPLIT and STOP together, extra requests pulsed while busy
        send_word(32'h0000000F, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            tx_if.iTXD_DATA     = 32'hFFFFFFFF;
            tx_if.iTXD_START_EN = 1'b1;
            tx_if.iTXD_REQ      = 1'b1;
            tick();
            tx_if.iTXD_REQ = 1'b0;
            tick();
        end
        wait_idle(fall);
        repeat (12) tick();
        check_eq("t5_busy_after", {31'd0, tx_if.oTXD_BUSY}, 32'd0);
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A};
        expect_frame("T5_split_stop", exp_q);

        // T6: reset before the 4th digit goes out
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, acc);
        begin
            int t;
            t = 0;
            while (got_q.size() < 3 && t < 200) begin
                tick();
                t++;
            end
            if (t >= 200) check_eq("t6_wait_timeout", t, 0);
        end
        rst = 1'b1;
        tick();
        check_eq("t6_rst_busy",     {31'd0, tx_if.oTXD_BUSY}, 32'd0);
        check_eq("t6_rst_uart_req", {31'd0, tx_if.oUART_REQ}, 32'd0);
        check_eq("t6_rst_uart_data", {24'd0, tx_if.oUART_DATA}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        exp_q = '{8'h43, 8'h41, 8'h46};
        expect_frame("T6_truncated", exp_q);
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(fall);
        exp_q = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44};
        expect_frame("T6_restart", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
